tile_render_sequencer: RTL and testbench

TILE_RENDER_SEQUENCER -- requirements
Module: tile_render_sequencer

---
 rtl/tile_render_sequencer.sv | 145 ++++++++++++++
 tb/tb_tile_render_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_render_sequencer.sv
// Tile render sequencer: walks the 64 pixels of an 8x8 tile in raster order, one
// handshaked request per pixel. Optional checksum register: TILE_SEQ_CHECKSUM_EN.
module tile_render_sequencer #(
   parameter logic [23:0] PIXEL_SEED     = 24'hA5C35A,
   parameter int          TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  cmd_mode,
   input  logic        cmd_texture,
   output logic [7:0]  pixel_r,
   output logic [7:0]  pixel_g,
   output logic [7:0]  pixel_b,
   output logic [5:0]  coord_x,
   output logic [5:0]  coord_y,
   output logic [1:0]  render_mode,
   output logic        pixel_write,
   output logic        texture_read,
   input  logic [7:0]  in_r,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_b,
   input  logic        render_ready,
   output logic        busy,
   output logic        done,
   output logic        timeout_err,
   output logic [6:0]  pix_count,
   output logic [15:0] checksum
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOW, DONE} state_t;

   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

   state_t        state, state_nxt;
   logic [5:0]    idx;
   logic [5:0]    idx_nxt;
   logic [TW-1:0] wait_cnt;
   logic          tex_q;
   logic          go, accept, advance, expire;

   assign idx_nxt = idx + 6'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      accept    = 1'b0;
      advance   = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               go        = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (render_ready) begin
               accept    = 1'b1;
               state_nxt = WAIT_LOW;
            end else if (wait_cnt == TW'(TIMEOUT_CYCLES)) begin
               // this cycle pushes the idle count past the limit
               expire    = 1'b1;
               state_nxt = DONE;
            end
         end
         WAIT_LOW: begin
            if (!render_ready) begin
               if (pix_count < 7'd64) begin
                  advance   = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx                         <= '0;
         wait_cnt                    <= '0;
         tex_q                       <= 1'b0;
         render_mode                 <= '0;
         {pixel_r, pixel_g, pixel_b} <= '0;
         coord_x                     <= '0;
         coord_y                     <= '0;
         pix_count                   <= '0;
         timeout_err                 <= 1'b0;
      end else begin
         if (go) begin
            idx                         <= '0;
            wait_cnt                    <= '0;
            tex_q                       <= cmd_texture;
            render_mode                 <= cmd_mode;
            {pixel_r, pixel_g, pixel_b} <= PIXEL_SEED;
            coord_x                     <= '0;
            coord_y                     <= '0;
            pix_count                   <= '0;
            timeout_err                 <= 1'b0;
         end
         if (accept && pix_count < 7'd64)
            pix_count <= pix_count + 7'd1;
         if (state == ISSUE && !render_ready && !expire)
            wait_cnt <= wait_cnt + TW'(1);
         if (expire)
            timeout_err <= 1'b1;
         // request fields are registered so they stay put for the whole handshake
         if (advance) begin
            idx                         <= idx_nxt;
            wait_cnt                    <= '0;
            {pixel_r, pixel_g, pixel_b} <= PIXEL_SEED ^ {18'b0, idx_nxt};
            coord_x                     <= {3'b0, idx_nxt[2:0]};
            coord_y                     <= {3'b0, idx_nxt[5:3]};
         end
      end
   end

   assign pixel_write  = (state == ISSUE) && !tex_q && !render_ready;
   assign texture_read = (state == ISSUE) &&  tex_q && !render_ready;
   assign busy         = (state == ISSUE) || (state == WAIT_LOW);
   assign done         = (state == DONE);

`ifdef TILE_SEQ_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         checksum <= '0;
      else if (go)
         checksum <= '0;
      else if (accept)
         checksum <= {checksum[14:0], checksum[15]} ^ {in_r ^ in_b, in_g};
   end
`else
   logic unused_rsp;
   assign unused_rsp = ^{in_r, in_g, in_b};
   assign checksum   = 16'h0000;
`endif

endmodule

// File: tb/tb_tile_render_sequencer.sv
// Bench for tile_render_sequencer: randomized responder plus a pixel-index model of
// the expected request stream, checked on every cycle a request is outstanding.
module tb_tile_render_sequencer;
   localparam logic [23:0] SEED = 24'hA5C35A;
   localparam int          TMO  = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  cmd_mode = '0;
   logic        cmd_texture = 1'b0;
   logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
   logic        rr_resp = 1'b0, rr_poke = 1'b0;
   logic        render_ready;
   logic [7:0]  pixel_r, pixel_g, pixel_b;
   logic [5:0]  coord_x, coord_y;
   logic [1:0]  render_mode;
   logic        pixel_write, texture_read, busy, done, timeout_err;
   logic [6:0]  pix_count;
   logic [15:0] checksum;
   logic        strobe;

   assign render_ready = rr_resp | rr_poke;
   assign strobe       = pixel_write | texture_read;

   int checks = 0, errors = 0;

   // pass description, owned by the main sequence
   logic [1:0] m_mode = '0;
   logic       m_tex = 1'b0;
   int         pass_id = 0;
   bit         resp_en = 1'b0;
   int         dly_lo = 4, dly_hi = 4, hold_lo = 2, hold_hi = 2, data_mode = 0;

   // responder and model state, owned by the responder
   int          seen_pass = 0, n_acc = 0, rstate = 0, dcnt = 0, hcnt = 0;
   logic [15:0] exp_ck = '0;
   logic [23:0] first_rgb = '0, last_rgb = '0;
   logic [11:0] last_xy = '0;

   tile_render_sequencer #(.PIXEL_SEED(SEED), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_mode(cmd_mode),
      .cmd_texture(cmd_texture), .pixel_r(pixel_r), .pixel_g(pixel_g),
      .pixel_b(pixel_b), .coord_x(coord_x), .coord_y(coord_y),
      .render_mode(render_mode), .pixel_write(pixel_write),
      .texture_read(texture_read), .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .render_ready(render_ready), .busy(busy), .done(done),
      .timeout_err(timeout_err), .pix_count(pix_count), .checksum(checksum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model_ck();
`ifdef TILE_SEQ_CHECKSUM_EN
      return exp_ck;
`else
      return 16'h0000;
`endif
   endfunction

   // responder + per-cycle compare, both away from the rising edge
   always @(negedge clk) begin
      logic [23:0] rsp;
      if (!rst_n) begin
         rr_resp = 1'b0;
         rstate  = 0;
      end else begin
         if (seen_pass != pass_id) begin
            seen_pass = pass_id;
            n_acc     = 0;
            exp_ck    = '0;
            rstate    = 0;
         end
         chk("busy_done_exclusive", {63'b0, busy & done}, 64'd0);
         if (render_ready) chk("strobe_low_when_ready", {62'b0, pixel_write, texture_read}, 64'd0);
         if (!busy) chk("strobe_low_when_not_busy", {63'b0, strobe}, 64'd0);
         if (strobe) begin
            chk("strobe_kind", {62'b0, pixel_write, texture_read}, m_tex ? 64'd1 : 64'd2);
            chk("req_rgb", {pixel_r, pixel_g, pixel_b}, SEED ^ 24'(n_acc));
            chk("req_xy", {coord_x, coord_y}, {6'(n_acc % 8), 6'(n_acc / 8)});
            chk("req_mode", render_mode, m_mode);
            chk("req_pix_count", pix_count, 64'(n_acc));
            if (n_acc == 0) first_rgb = {pixel_r, pixel_g, pixel_b};
            last_rgb = {pixel_r, pixel_g, pixel_b};
            last_xy  = {coord_x, coord_y};
         end
         if (rstate == 2) begin
            hcnt--;
            if (hcnt == 0) begin
               rr_resp = 1'b0;
               rstate  = 0;
            end
         end else if (rstate == 1) begin
            chk("req_held_until_ready", {63'b0, strobe}, 64'd1);
         end else if (resp_en && strobe) begin
            dcnt   = $urandom_range(dly_hi, dly_lo);
            hcnt   = $urandom_range(hold_hi, hold_lo);
            rstate = 1;
         end
         if (rstate == 1) begin
            if (dcnt == 0) begin
               if (data_mode == 1) rsp = (n_acc == 0) ? 24'h000100 : 24'h000000;
               else                rsp = 24'($urandom);
               {in_r, in_g, in_b} = rsp;
               rr_resp = 1'b1;
               exp_ck  = {exp_ck[14:0], exp_ck[15]} ^ {rsp[23:16] ^ rsp[7:0], rsp[15:8]};
               n_acc++;
               rstate  = 2;
            end else begin
               dcnt--;
            end
         end
      end
   end

   task automatic do_start(input logic [1:0] m, input logic t);
      @(negedge clk); #2;
      cmd_mode = m; cmd_texture = t; m_mode = m; m_tex = t;
      pass_id++;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // scramble the command inputs: the pass must use the latched copy
      cmd_mode = 2'($urandom); cmd_texture = 1'($urandom);
   endtask

   task automatic wait_done(input int budget);
      int i;
      i = 0;
      while (!done && i < budget) begin
         @(posedge clk); #1;
         i++;
      end
      chk("pass_reaches_done", {63'b0, done}, 64'd1);
   endtask

   task automatic end_checks();
      chk("end_pix_count", pix_count, 64'd64);
      chk("end_accepted", 64'(n_acc), 64'd64);
      chk("end_busy", {63'b0, busy}, 64'd0);
      chk("end_timeout_err", {63'b0, timeout_err}, 64'd0);
      chk("end_strobes", {63'b0, strobe}, 64'd0);
      chk("end_checksum", checksum, model_ck());
      chk("end_last_req", {pixel_r, pixel_g, pixel_b, coord_x, coord_y}, {SEED ^ 24'd63, 6'd7, 6'd7});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation ran past its time budget");
      $fatal(1, "time limit");
   end

   initial begin
      int n;
      // reset held two cycles
      repeat (2) @(posedge clk);
      #1;
      chk("reset_request_outputs",
          {pixel_r, pixel_g, pixel_b, coord_x, coord_y, render_mode, pixel_write, texture_read}, 64'd0);
      chk("reset_status_outputs", {busy, done, timeout_err, pix_count, checksum}, 64'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;

      // full pixel_write pass, mode 2, ready 4 cycles after strobe for 2 cycles
      resp_en = 1'b1; dly_lo = 4; dly_hi = 4; hold_lo = 2; hold_hi = 2; data_mode = 0;
      do_start(2'd2, 1'b0);
      chk("start_busy", {busy, done}, 64'd2);
      wait_done(3000);
      end_checks();
      chk("first_pixel", first_rgb, 64'hA5C35A);
      chk("last_pixel", last_rgb, 64'hA5C365);
      chk("last_coord", last_xy, {6'd7, 6'd7});

      // render_ready while in DONE changes nothing
      @(negedge clk); #2;
      rr_poke = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("done_ignores_ready", {done, busy, pix_count}, {1'b1, 1'b0, 7'd64});
      chk("done_ignores_ready_ck", checksum, model_ck());
      @(negedge clk); #2;
      rr_poke = 1'b0;

      // randomized passes, both request kinds
      for (int p = 0; p < 4; p++) begin
         dly_lo = 0; dly_hi = 8; hold_lo = 1; hold_hi = 3;
         do_start(2'($urandom), 1'(p));
         wait_done(3000);
         end_checks();
      end

      // checksum pin: only pixel 0 returns 24'h000100
      data_mode = 1; dly_lo = 1; dly_hi = 1; hold_lo = 1; hold_hi = 1;
      do_start(2'd1, 1'b1);
      wait_done(3000);
      end_checks();
`ifdef TILE_SEQ_CHECKSUM_EN
      chk("checksum_literal", checksum, 64'h8000);
`else
      chk("checksum_literal", checksum, 64'h0000);
`endif
      data_mode = 0;

      // timeout: responder silent
      resp_en = 1'b0;
      do_start(2'd3, 1'b0);
      n = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         if (strobe) n++;
         @(posedge clk); #1;
      end
      chk("timeout_issue_cycles", 64'(n), 64'(TMO + 1));
      chk("timeout_status", {done, busy, timeout_err, pix_count}, {1'b1, 1'b0, 1'b1, 7'd0});
      chk("timeout_strobes", {63'b0, strobe}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("timeout_sticky", {63'b0, timeout_err}, 64'd1);

      // next start clears the sticky error
      resp_en = 1'b1; dly_lo = 0; dly_hi = 3; hold_lo = 1; hold_hi = 2;
      do_start(2'd0, 1'b1);
      chk("restart_clears", {timeout_err, done, busy}, 64'd1);
      wait_done(3000);
      end_checks();

      // reset while pixel 10 is outstanding
      dly_lo = 2; dly_hi = 2; hold_lo = 1; hold_hi = 1;
      do_start(2'd1, 1'b0);
      n = 0;
      while (!(n_acc == 10 && strobe) && n < 2000) begin
         @(negedge clk); #2;
         n++;
      end
      chk("reached_pixel_10", {63'b0, n_acc == 10 && strobe}, 64'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midreset_strobes", {62'b0, pixel_write, texture_read}, 64'd0);
      chk("midreset_status", {busy, done, timeout_err, pix_count, checksum}, 64'd0);
      chk("midreset_request", {pixel_r, pixel_g, pixel_b, coord_x, coord_y, render_mode}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("midreset_no_resume", {busy, strobe}, 64'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("after_reset_idle", {busy, done, strobe}, 64'd0);
      do_start(2'd2, 1'b1);
      chk("restart_first_req", {pixel_r, pixel_g, pixel_b, coord_x, coord_y, pix_count},
          {24'hA5C35A, 6'd0, 6'd0, 7'd0});
      wait_done(3000);
      end_checks();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
